// File: rtl/amo_unit_pkg.sv
// Shared definitions for the atomic memory operation unit: RISC-V AMO/load encodings,
// FSM state type and the latched request record.
package WivDefines;

  localparam int AMO_XLEN = 64;

  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } funct5_amo_type_t;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_D  = 3'd3,
    LD_BU = 3'd4,
    LD_HU = 3'd5,
    LD_WU = 3'd6
  } funct3_ld_type_t;

  typedef enum logic [1:0] {
    AMO_IDLE,
    AMO_READ,
    AMO_WRITE,
    AMO_RESP
  } amo_state_t;

  // Address is split into doubleword index and word lane; byte offset is only needed at decode.
  typedef struct packed {
    funct5_amo_type_t        funct5;
    logic                    is_word;
    logic [AMO_XLEN-1:3]     dw_addr;
    logic                    lane;
    logic [AMO_XLEN-1:0]     data;
  } amo_req_t;

  function automatic logic is_amo_funct5(input logic [4:0] f);
    case (f)
      AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR,
      AMO_AND, AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: is_amo_funct5 = 1'b1;
      default:                                       is_amo_funct5 = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] wmask_for(input logic is_word, input logic lane);
    if (!is_word)  wmask_for = 8'hFF;
    else if (lane) wmask_for = 8'hF0;
    else           wmask_for = 8'h0F;
  endfunction

endpackage

// File: rtl/amo_unit_alu.sv
// Combinational AMO operator: result = op(a, b). For word ops only result[31:0] is meaningful,
// and comparisons look at the low 32 bits only.
module amo_alu
  import WivDefines::*;
#(
  parameter int XLEN = 64
) (
  input  funct5_amo_type_t  funct5,
  input  logic              is_word,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   result
);

  logic lt_s, lt_u;
  logic signed [31:0] a_w_s, b_w_s;
  logic signed [XLEN-1:0] a_d_s, b_d_s;

  always_comb begin
    a_w_s = a[31:0];
    b_w_s = b[31:0];
    a_d_s = a;
    b_d_s = b;
    if (is_word) begin
      lt_s = a_w_s < b_w_s;
      lt_u = a[31:0] < b[31:0];
    end else begin
      lt_s = a_d_s < b_d_s;
      lt_u = a < b;
    end
  end

  always_comb begin
    case (funct5)
      AMO_ADD:  result = a + b;
      AMO_SWAP: result = b;
      AMO_SC:   result = b;
      AMO_XOR:  result = a ^ b;
      AMO_OR:   result = a | b;
      AMO_AND:  result = a & b;
      AMO_MIN:  result = lt_s ? a : b;
      AMO_MAX:  result = lt_s ? b : a;
      AMO_MINU: result = lt_u ? a : b;
      AMO_MAXU: result = lt_u ? b : a;
      default:  result = a;
    endcase
  end

endmodule

// File: rtl/amo_unit.sv
// Atomic memory operation sequencer: read-modify-write over a doubleword memory port,
// plus the LR/SC reservation register.
module amo_unit
  import WivDefines::*;
#(
  parameter int XLEN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_funct5,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_data,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_data,
  output logic             resp_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [7:0]       mem_wmask,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             snoop_valid,
  input  logic [XLEN-1:0]  snoop_addr,
  input  logic             clear_resv
);

  localparam int NUM_LANES = XLEN / 32;

  amo_state_t state;
  amo_req_t   req_q;

  logic              resv_valid;
  logic [XLEN-1:3]   resv_addr;

  assign req_ready = (state == AMO_IDLE);

  logic req_fire;
  assign req_fire = req_valid && req_ready;

  // Request decode on the raw inputs, used in the accept cycle only.
  logic in_word, in_f3_ok, in_misalign, in_err, in_is_sc, resv_hit;
  always_comb begin
    in_word     = (req_funct3 == LD_W);
    in_f3_ok    = (req_funct3 == LD_W) || (req_funct3 == LD_D);
    in_misalign = in_word ? (|req_addr[1:0]) : (|req_addr[2:0]);
    in_err      = !in_f3_ok || in_misalign || !is_amo_funct5(req_funct5);
    in_is_sc    = (req_funct5 == AMO_SC);
    resv_hit    = resv_valid && (resv_addr == req_addr[XLEN-1:3]);
  end

  logic [NUM_LANES-1:0][31:0] rd_lanes;
  logic [XLEN-1:0]            loaded, alu_res, wdata_next;

  assign rd_lanes = mem_rdata;

  always_comb begin
    if (req_q.is_word)
      loaded = {{(XLEN-32){rd_lanes[req_q.lane][31]}}, rd_lanes[req_q.lane]};
    else
      loaded = mem_rdata;
    wdata_next = req_q.is_word ? {NUM_LANES{alu_res[31:0]}} : alu_res;
  end

  amo_alu #(.XLEN(XLEN)) u_alu (
    .funct5  (req_q.funct5),
    .is_word (req_q.is_word),
    .a       (loaded),
    .b       (req_q.data),
    .result  (alu_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= AMO_IDLE;
      req_q      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        AMO_IDLE: if (req_fire) begin
          req_q.funct5  <= funct5_amo_type_t'(req_funct5);
          req_q.is_word <= in_word;
          req_q.dw_addr <= req_addr[XLEN-1:3];
          req_q.lane    <= req_addr[2];
          req_q.data    <= req_data;
          mem_addr      <= {req_addr[XLEN-1:3], 3'b000};
          mem_wmask     <= wmask_for(in_word, req_addr[2]);
          resp_err      <= 1'b0;
          if (in_err) begin
            state      <= AMO_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
          end else if (in_is_sc) begin
            if (resv_hit) begin
              state     <= AMO_WRITE;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= in_word ? {NUM_LANES{req_data[31:0]}} : req_data;
            end else begin
              state      <= AMO_RESP;
              resp_valid <= 1'b1;
              resp_data  <= {{(XLEN-1){1'b0}}, 1'b1};
            end
          end else begin
            state   <= AMO_READ;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
          end
        end
        AMO_READ: if (mem_ack) begin
          resp_data <= loaded;
          if (req_q.funct5 == AMO_LR) begin
            state      <= AMO_RESP;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
          end else begin
            state     <= AMO_WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= wdata_next;
          end
        end
        AMO_WRITE: if (mem_ack) begin
          state      <= AMO_RESP;
          mem_req    <= 1'b0;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          if (req_q.funct5 == AMO_SC) resp_data <= '0;
        end
        AMO_RESP: state <= AMO_IDLE;
        default:  state <= AMO_IDLE;
      endcase
    end
  end

  // A snoop is compared against the address being reserved this cycle, so a hit kills an LR in flight.
  logic            lr_set, resv_kill;
  logic [XLEN-1:3] resv_cmp;
  always_comb begin
    lr_set    = (state == AMO_READ) && mem_ack && (req_q.funct5 == AMO_LR);
    resv_cmp  = lr_set ? req_q.dw_addr : resv_addr;
    resv_kill = clear_resv
             || (snoop_valid && (snoop_addr[XLEN-1:3] == resv_cmp))
             || (req_fire && in_is_sc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (resv_kill) begin
      resv_valid <= 1'b0;
    end else if (lr_set) begin
      resv_valid <= 1'b1;
      resv_addr  <= req_q.dw_addr;
    end
  end

  logic unused_snoop_lsb;
  assign unused_snoop_lsb = ^snoop_addr[2:0];

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit: vector table of single operations plus hand-written
// reservation and reset-abandon sequences, against a small byte-masked memory model.
module tb_amo_unit;
  import WivDefines::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [4:0]  req_funct5;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_data;
  logic        resp_valid, resp_err;
  logic [63:0] resp_data;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        snoop_valid, clear_resv;
  logic [63:0] snoop_addr;

  always #5 clk = ~clk;

  amo_unit #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct5(req_funct5), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .clear_resv(clear_resv)
  );

  // Memory model: zero-wait ack, write ack can be withheld, ack can be forced for stray-ack tests.
  logic        ack_gate, wr_ack_en, ack_force;
  logic        pre_en;
  logic [10:0] pre_idx;
  logic [63:0] pre_val;
  logic [63:0] mem [0:2047];
  int          memreq_cycles = 0;
  int          wr_count = 0;
  logic [63:0] last_wdata = '0;
  logic [7:0]  last_wmask = '0;

  assign mem_ack   = (mem_req && ack_gate && (!mem_we || wr_ack_en)) || ack_force;
  assign mem_rdata = mem[mem_addr[13:3]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (mem_req) memreq_cycles <= memreq_cycles + 1;
    if (mem_req && mem_we && mem_ack) begin
      for (int b = 0; b < 8; b++)
        if (mem_wmask[b]) mem[mem_addr[13:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
      wr_count   <= wr_count + 1;
      last_wdata <= mem_wdata;
      last_wmask <= mem_wmask;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [63:0] addr, input logic [63:0] val);
    @(negedge clk);
    pre_idx = addr[13:3];
    pre_val = val;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [4:0] f5, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] data,
                       output logic [63:0] rdata, output logic err, output int lat,
                       output int nreq, output int nwr);
    int r0, w0;
    @(negedge clk);
    r0 = memreq_cycles;
    w0 = wr_count;
    chk({name, ".ready"}, {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_funct5 = f5;
    req_funct3 = f3;
    req_addr   = addr;
    req_data   = data;
    @(posedge clk);
    lat = 0; rdata = '0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) begin
        lat = i; rdata = resp_data; err = resp_err;
        break;
      end
    end
    if (lat == 0) begin
      tests++; fails++;
      $display("FAIL %s.timeout: got no resp_valid expected one within 20 cycles", name);
    end
    @(negedge clk);
    chk({name, ".pulse"}, {63'd0, resp_valid}, 64'd0);
    nreq = memreq_cycles - r0;
    nwr  = wr_count - w0;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  f5;
    logic [2:0]  f3;
    logic [63:0] addr, rs2, init;
    logic [63:0] exp_resp;
    logic        exp_err;
    int          exp_lat, exp_nreq, exp_nwr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;
  } vec_t;

  vec_t vecs[$];

  logic [63:0] rd;
  logic        er;
  int          lat, nreq, nwr;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_funct5 = '0; req_funct3 = '0;
    req_addr = '0; req_data = '0; snoop_valid = 1'b0; snoop_addr = '0; clear_resv = 1'b0;
    ack_gate = 1'b1; wr_ack_en = 1'b1; ack_force = 1'b0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;

    //            name        f5       f3    addr       rs2                      init                     resp                     err lat req wr wdata                    mask
    vecs.push_back('{"addD",   AMO_ADD,  3'd3, 64'h1000, 64'd3,                   64'd5,                   64'd5,                   0, 3, 2, 1, 64'd8,                   8'hFF});
    vecs.push_back('{"addW",   AMO_ADD,  3'd2, 64'h1004, 64'd1,                   64'hFFFFFFFF_00000000,   64'hFFFFFFFF_FFFFFFFF,   0, 3, 2, 1, 64'h0,                   8'hF0});
    vecs.push_back('{"minW",   AMO_MIN,  3'd2, 64'h1000, 64'd1,                   64'h00000000_80000000,   64'hFFFFFFFF_80000000,   0, 3, 2, 1, 64'h80000000_80000000,   8'h0F});
    vecs.push_back('{"minuW",  AMO_MINU, 3'd2, 64'h1000, 64'd1,                   64'h00000000_80000000,   64'hFFFFFFFF_80000000,   0, 3, 2, 1, 64'h00000001_00000001,   8'h0F});
    vecs.push_back('{"maxD",   AMO_MAX,  3'd3, 64'h1008, 64'd3,                   64'hFFFFFFFF_FFFFFFFE,   64'hFFFFFFFF_FFFFFFFE,   0, 3, 2, 1, 64'd3,                   8'hFF});
    vecs.push_back('{"maxuD",  AMO_MAXU, 3'd3, 64'h1008, 64'd3,                   64'hFFFFFFFF_FFFFFFFE,   64'hFFFFFFFF_FFFFFFFE,   0, 3, 2, 1, 64'hFFFFFFFF_FFFFFFFE,   8'hFF});
    vecs.push_back('{"xorD",   AMO_XOR,  3'd3, 64'h1010, 64'h0FF0,                64'hF0F0,                64'hF0F0,                0, 3, 2, 1, 64'hFF00,                8'hFF});
    vecs.push_back('{"orW",    AMO_OR,   3'd2, 64'h1014, 64'hF,                   64'h12345678_00000000,   64'h00000000_12345678,   0, 3, 2, 1, 64'h1234567F_1234567F,   8'hF0});
    vecs.push_back('{"andW",   AMO_AND,  3'd2, 64'h1018, 64'hF,                   64'h00000000_F00000FF,   64'hFFFFFFFF_F00000FF,   0, 3, 2, 1, 64'h0000000F_0000000F,   8'h0F});
    vecs.push_back('{"swapD",  AMO_SWAP, 3'd3, 64'h1020, 64'hBEEF,                64'hDEAD,                64'hDEAD,                0, 3, 2, 1, 64'hBEEF,                8'hFF});
    vecs.push_back('{"maxW",   AMO_MAX,  3'd2, 64'h1024, 64'hFFFFFFFF_FFFFFFFF,   64'h7FFFFFFF_00000000,   64'h00000000_7FFFFFFF,   0, 3, 2, 1, 64'h7FFFFFFF_7FFFFFFF,   8'hF0});
    vecs.push_back('{"misW",   AMO_SWAP, 3'd2, 64'h1002, 64'd9,                   64'd0,                   64'd0,                   1, 1, 0, 0, 64'd0,                   8'h00});
    vecs.push_back('{"f3zero", AMO_ADD,  3'd0, 64'h1000, 64'd9,                   64'd0,                   64'd0,                   1, 1, 0, 0, 64'd0,                   8'h00});
    vecs.push_back('{"misD",   AMO_ADD,  3'd3, 64'h1004, 64'd9,                   64'd0,                   64'd0,                   1, 1, 0, 0, 64'd0,                   8'h00});
    vecs.push_back('{"badf5",  5'b00101, 3'd3, 64'h1000, 64'd9,                   64'd0,                   64'd0,                   1, 1, 0, 0, 64'd0,                   8'h00});
    vecs.push_back('{"scNoRes",AMO_SC,   3'd3, 64'h3000, 64'd9,                   64'd0,                   64'd1,                   0, 1, 0, 0, 64'd0,                   8'h00});
    vecs.push_back('{"lrW",    AMO_LR,   3'd2, 64'h1004, 64'd0,                   64'h80000001_00000000,   64'hFFFFFFFF_80000001,   0, 2, 1, 0, 64'd0,                   8'h00});
    vecs.push_back('{"scW",    AMO_SC,   3'd2, 64'h1000, 64'd5,                   64'h80000001_00000000,   64'd0,                   0, 2, 1, 1, 64'h00000005_00000005,   8'h0F});
    vecs.push_back('{"scAgain",AMO_SC,   3'd2, 64'h1000, 64'd5,                   64'd0,                   64'd1,                   0, 1, 0, 0, 64'd0,                   8'h00});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready",     {63'd0, req_ready},  64'd1);
    chk("rst.resp_valid",{63'd0, resp_valid}, 64'd0);
    chk("rst.resp_err",  {63'd0, resp_err},   64'd0);
    chk("rst.mem_req",   {63'd0, mem_req},    64'd0);
    chk("rst.mem_we",    {63'd0, mem_we},     64'd0);
    chk("rst.resp_data", resp_data,           64'd0);
    chk("rst.mem_addr",  mem_addr,            64'd0);
    chk("rst.mem_wdata", mem_wdata,           64'd0);
    chk("rst.mem_wmask", {56'd0, mem_wmask},  64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      preload(vecs[i].addr, vecs[i].init);
      do_op(vecs[i].name, vecs[i].f5, vecs[i].f3, vecs[i].addr, vecs[i].rs2, rd, er, lat, nreq, nwr);
      chk({vecs[i].name, ".resp"}, rd, vecs[i].exp_resp);
      chk({vecs[i].name, ".err"},  {63'd0, er}, {63'd0, vecs[i].exp_err});
      chk({vecs[i].name, ".lat"},  64'(lat),  64'(vecs[i].exp_lat));
      chk({vecs[i].name, ".nreq"}, 64'(nreq), 64'(vecs[i].exp_nreq));
      chk({vecs[i].name, ".nwr"},  64'(nwr),  64'(vecs[i].exp_nwr));
      if (vecs[i].exp_nwr > 0) begin
        chk({vecs[i].name, ".wdata"}, last_wdata, vecs[i].exp_wdata);
        chk({vecs[i].name, ".wmask"}, {56'd0, last_wmask}, {56'd0, vecs[i].exp_wmask});
      end
    end

    // LR.D / SC.D success, then a snoop to the same doubleword breaks the pair.
    preload(64'h2000, 64'h55);
    do_op("lrD", AMO_LR, 3'd3, 64'h2000, 64'd0, rd, er, lat, nreq, nwr);
    chk("lrD.resp", rd, 64'h55);
    do_op("scD", AMO_SC, 3'd3, 64'h2000, 64'd7, rd, er, lat, nreq, nwr);
    chk("scD.resp", rd, 64'd0);
    chk("scD.nwr", 64'(nwr), 64'd1);
    chk("scD.wdata", last_wdata, 64'd7);
    chk("scD.mem", mem[64'h2000 >> 3], 64'd7);

    do_op("lrD2", AMO_LR, 3'd3, 64'h2000, 64'd0, rd, er, lat, nreq, nwr);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_addr = 64'h2004;
    @(negedge clk);
    snoop_valid = 1'b0;
    do_op("scSnoop", AMO_SC, 3'd3, 64'h2000, 64'd9, rd, er, lat, nreq, nwr);
    chk("scSnoop.resp", rd, 64'd1);
    chk("scSnoop.nreq", 64'(nreq), 64'd0);

    // Snoop to a different doubleword leaves the reservation intact.
    do_op("lrD3", AMO_LR, 3'd3, 64'h2000, 64'd0, rd, er, lat, nreq, nwr);
    @(negedge clk);
    snoop_valid = 1'b1; snoop_addr = 64'h2008;
    @(negedge clk);
    snoop_valid = 1'b0;
    do_op("scOther", AMO_SC, 3'd3, 64'h2000, 64'd11, rd, er, lat, nreq, nwr);
    chk("scOther.resp", rd, 64'd0);

    // clear_resv kills a reservation.
    do_op("lrD4", AMO_LR, 3'd3, 64'h2000, 64'd0, rd, er, lat, nreq, nwr);
    @(negedge clk);
    clear_resv = 1'b1;
    @(negedge clk);
    clear_resv = 1'b0;
    do_op("scClr", AMO_SC, 3'd3, 64'h2000, 64'd9, rd, er, lat, nreq, nwr);
    chk("scClr.resp", rd, 64'd1);

    // A matching snoop in the same cycle as the LR read completes wins over the set.
    snoop_valid = 1'b1; snoop_addr = 64'h2000;
    do_op("lrSnoop", AMO_LR, 3'd3, 64'h2000, 64'd0, rd, er, lat, nreq, nwr);
    snoop_valid = 1'b0;
    do_op("scRace", AMO_SC, 3'd3, 64'h2000, 64'd9, rd, er, lat, nreq, nwr);
    chk("scRace.resp", rd, 64'd1);

    // Reset during WRITE with the write ack withheld abandons the AMO and the reservation.
    do_op("lrD5", AMO_LR, 3'd3, 64'h2000, 64'd0, rd, er, lat, nreq, nwr);
    preload(64'h1000, 64'd5);
    wr_ack_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_funct5 = AMO_ADD; req_funct3 = 3'd3;
    req_addr = 64'h1000; req_data = 64'd3;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin lat = i; break; end
    end
    chk("rstW.reached_write", 64'(lat), 64'd2);
    chk("rstW.req_held", {63'd0, mem_req}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ack_force = 1'b1;
    chk("rstW.mem_req",    {63'd0, mem_req},    64'd0);
    chk("rstW.mem_we",     {63'd0, mem_we},     64'd0);
    chk("rstW.resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rstW.resp_data",  resp_data,           64'd0);
    chk("rstW.mem_wmask",  {56'd0, mem_wmask},  64'd0);
    chk("rstW.ready",      {63'd0, req_ready},  64'd1);
    @(negedge clk);
    ack_force = 1'b0;
    wr_ack_en = 1'b1;
    chk("rstW.stray_ack_resp", {63'd0, resp_valid}, 64'd0);
    chk("rstW.stray_ack_req",  {63'd0, mem_req},    64'd0);
    chk("rstW.mem_untouched",  mem[64'h1000 >> 3],  64'd5);
    do_op("scAfterRst", AMO_SC, 3'd3, 64'h2000, 64'd9, rd, er, lat, nreq, nwr);
    chk("scAfterRst.resp", rd, 64'd1);
    chk("scAfterRst.nreq", 64'(nreq), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amo_unit.md
AMO_UNIT -- requirements
Module: amo_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data/address width; only 64 is supported.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req_valid in 1 / req_ready out 1  upstream request handshake from the MEM stage.
REQ-005 SHALL have ports req_funct5 in 5 (funct5_amo_type_t), req_funct3 in 3 (2=W, 3=D), req_addr in 64, req_data in 64 (rs2 value).
REQ-006 SHALL have ports resp_valid out 1, resp_data out 64 (rd value), resp_err out 1  response to upstream.
REQ-007 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 64, mem_wdata out 64, mem_wmask out 8, mem_ack in 1, mem_rdata in 64  doubleword memory port.
REQ-008 SHALL have ports snoop_valid in 1, snoop_addr in 64 (external store observed), clear_resv in 1 (trap/MRET).

Function
REQ-009 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL latch funct5, funct3, addr, data on req_valid&&req_ready.
REQ-011 SHALL flag an error on accept for: funct3 not 2/3; W with addr[1:0]!=0; D with addr[2:0]!=0; funct5 not in funct5_amo_type_t. Errors go IDLE->RESP with resp_err=1, resp_data=0, no memory access.
REQ-012 SHALL drive mem_addr={addr[63:3],3'b0}; mem_req=1 in READ (mem_we=0) and in WRITE (mem_we=1), held until mem_ack; mem_ack outside READ/WRITE is ignored.
REQ-013 SHALL select the W lane by addr[2]: loaded value is mem_rdata[31:0] or [63:32], sign-extended; mem_wmask 8'h0F/8'hF0, mem_wdata = the 32-bit result replicated to both halves. D: mask 8'hFF.
REQ-014 AMO ops (ADD, SWAP, XOR, OR, AND, MIN, MAX, MINU, MAXU): IDLE->READ->(ack)->WRITE with op(loaded, rs2)->(ack)->RESP; resp_data = original loaded value (sign-extended for W).
REQ-015 W-width MIN/MAX SHALL compare 32-bit signed values, MINU/MAXU 32-bit unsigned values; D width SHALL use 64-bit comparisons.
REQ-016 LR: READ only, then RESP with the loaded value; SHALL set the reservation (valid, addr[63:3]).
REQ-017 SC with a valid reservation whose addr[63:3] matches: WRITE rs2, then resp_data=0. Otherwise: no memory access, RESP with resp_data=1. SC SHALL clear the reservation in either case.
REQ-018 Reservation SHALL clear on clear_resv, or on snoop_valid with snoop_addr[63:3] equal to the reservation address; clearing SHALL win over an LR set in the same cycle.
REQ-019 resp_valid SHALL be a one-cycle pulse in RESP; the next state is IDLE; there is no backpressure on resp.
REQ-020 Minimum latency from accept to resp_valid with zero-wait ack: AMO 3 cycles, LR 2 cycles, failed SC or error 1 cycle.

Reset
REQ-021 When rst_n=0 at an edge, the unit SHALL enter IDLE and clear the reservation; resp_valid, resp_err, mem_req and mem_we SHALL be 0; resp_data, mem_addr, mem_wdata and mem_wmask SHALL be 0.
REQ-022 Reset during READ/WRITE SHALL abandon the transaction with no response; a mem_ack arriving in the following cycle SHALL be ignored.

Structure
REQ-023 An amo_state_t enum SHALL be added to package WivDefines; the unit SHALL reuse funct5_amo_type_t and funct3_ld_type_t from it.
REQ-024 A combinational sub-module amo_alu(funct5, is_word, a, b -> result) SHALL compute the op result; sequencing, lanes and the reservation live in amo_unit.

Verification
REQ-025 AMOADD.D addr 0x1000, mem=5, rs2=3 -> write 8 with mask FF; resp_data=5; resp_valid 3 cycles after accept with immediate ack.
REQ-026 AMOADD.W addr 0x1004, mem=0xFFFFFFFF_00000000, rs2=1 -> wmask F0, wdata 0x00000000_00000000; resp_data=0xFFFFFFFF_FFFFFFFF.
REQ-027 AMOMIN.W vs AMOMINU.W with mem word 0x80000000 and rs2=1 -> writes 0x80000000 and 0x00000001 respectively.
REQ-028 LR.D 0x2000, then SC.D 0x2000 rs2=7 -> write 7, resp 0. Repeat with snoop_addr=0x2004 between the two -> SC resp 1, no mem_req.
REQ-029 AMOSWAP.W addr 0x1002 -> resp_err=1 one cycle after accept, no mem_req; funct3=0 -> same behaviour.
REQ-030 Assert rst_n=0 in WRITE with mem_ack withheld -> IDLE, mem_req=0, no resp_valid; a subsequent SC fails (resp 1).
